// File: rtl/pcie_rd_tag_tracker_if.sv
// Read-request / completion bus between the issuer, the RX completion path and the tag tracker.
interface pcie_rd_tag_tracker_if #(
  parameter int unsigned NUM_TAGS     = 128,
  parameter int unsigned MAX_RD_BYTES = 512,
  parameter int unsigned TAG_W        = $clog2(NUM_TAGS),
  parameter int unsigned BC_W         = $clog2(MAX_RD_BYTES + 1)
);
  logic             alloc_valid;
  logic [BC_W-1:0]  alloc_bytes;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cpl_valid;
  logic [TAG_W-1:0] cpl_tag;
  logic [BC_W-1:0]  cpl_bytes;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic             err_valid;
  logic [TAG_W-1:0] err_tag;
  logic [TAG_W:0]   outstanding;

  // Issuer / completion source side.
  modport master (
    output alloc_valid, alloc_bytes, cpl_valid, cpl_tag, cpl_bytes,
    input  alloc_ready, alloc_tag, done_valid, done_tag, err_valid, err_tag, outstanding
  );

  // Tracker side.
  modport slave (
    input  alloc_valid, alloc_bytes, cpl_valid, cpl_tag, cpl_bytes,
    output alloc_ready, alloc_tag, done_valid, done_tag, err_valid, err_tag, outstanding
  );
endinterface

// File: rtl/pcie_rd_tag_tracker.sv
// Tag allocator and per-tag completion byte counter for endpoint-issued PCIe memory reads.
// Define PCIE_RD_TAG_TRACKER_ERR_CHK_EN to report overrun and unallocated-tag completions.
module pcie_rd_tag_tracker #(
  parameter int unsigned NUM_TAGS     = 128,
  parameter int unsigned MAX_RD_BYTES = 512,
  parameter int unsigned TAG_W        = $clog2(NUM_TAGS),
  parameter int unsigned BC_W         = $clog2(MAX_RD_BYTES + 1)
) (
  input logic                  clk,
  input logic                  rst,
  pcie_rd_tag_tracker_if.slave bus_io
);

  localparam logic [TAG_W:0] CntOne = {{TAG_W{1'b0}}, 1'b1};

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [BC_W-1:0]     rem_q [NUM_TAGS];
  logic [BC_W-1:0]     rem_d [NUM_TAGS];
  logic                done_valid_q, done_valid_d;
  logic [TAG_W-1:0]    done_tag_q, done_tag_d;
  logic [TAG_W:0]      outstanding_q, outstanding_d;
  logic [TAG_W-1:0]    free_tag;
  logic                any_free;
  logic                alloc_fire;
  logic                tag_freed;
`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
  logic                err_valid_q, err_valid_d;
  logic [TAG_W-1:0]    err_tag_q, err_tag_d;
`endif

  // Lowest-index free tag: scan from the top so the lowest match wins.
  always_comb begin
    free_tag = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_tag = TAG_W'(i);
    end
  end

  assign any_free   = ~&busy_q;
  assign alloc_fire = bus_io.alloc_valid & any_free;

  always_comb begin
    busy_d       = busy_q;
    rem_d        = rem_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    tag_freed    = 1'b0;
`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
    err_valid_d  = 1'b0;
    err_tag_d    = err_tag_q;
`endif

    // The granted tag is free and a completing tag is busy, so these never collide.
    if (alloc_fire) begin
      busy_d[free_tag] = 1'b1;
      rem_d[free_tag]  = bus_io.alloc_bytes;
    end

    if (bus_io.cpl_valid) begin
      if (busy_q[bus_io.cpl_tag]) begin
        if (bus_io.cpl_bytes < rem_q[bus_io.cpl_tag]) begin
          rem_d[bus_io.cpl_tag] = rem_q[bus_io.cpl_tag] - bus_io.cpl_bytes;
        end else begin
          busy_d[bus_io.cpl_tag] = 1'b0;
          rem_d[bus_io.cpl_tag]  = '0;
          tag_freed              = 1'b1;
          done_valid_d           = 1'b1;
          done_tag_d             = bus_io.cpl_tag;
`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
          if (bus_io.cpl_bytes != rem_q[bus_io.cpl_tag]) begin
            err_valid_d = 1'b1;
            err_tag_d   = bus_io.cpl_tag;
          end
`endif
        end
      end
`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
      else begin
        err_valid_d = 1'b1;
        err_tag_d   = bus_io.cpl_tag;
      end
`endif
    end

    unique case ({alloc_fire, tag_freed})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      rem_q         <= '{default: '0};
      done_valid_q  <= 1'b0;
      done_tag_q    <= '0;
      outstanding_q <= '0;
    end else begin
      busy_q        <= busy_d;
      rem_q         <= rem_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_tag_q   <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_tag_q   <= err_tag_d;
    end
  end

  assign bus_io.err_valid = err_valid_q;
  assign bus_io.err_tag   = err_tag_q;
`else
  assign bus_io.err_valid = 1'b0;
  assign bus_io.err_tag   = '0;
`endif

  assign bus_io.alloc_ready = any_free;
  assign bus_io.alloc_tag   = free_tag;
  assign bus_io.done_valid  = done_valid_q;
  assign bus_io.done_tag    = done_tag_q;
  assign bus_io.outstanding = outstanding_q;

endmodule

// File: tb/tb_pcie_rd_tag_tracker.sv
// Randomized scoreboard bench for pcie_rd_tag_tracker against a per-tag byte-count model.
module tb_pcie_rd_tag_tracker;
  localparam int NT = 128;
  localparam int MB = 512;
  localparam int TW = 7;
  localparam int BW = 10;
`ifdef PCIE_RD_TAG_TRACKER_ERR_CHK_EN
  localparam bit ErrChk = 1'b1;
`else
  localparam bit ErrChk = 1'b0;
`endif

  typedef struct {
    int cyc;
    bit done;
    int dtag;
    bit err;
    int etag;
    int outs;
    bit rdy;
    int atag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  bit   m_busy[NT];
  int   m_rem[NT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pcie_rd_tag_tracker_if #(.NUM_TAGS(NT), .MAX_RD_BYTES(MB)) bus ();

  pcie_rd_tag_tracker #(.NUM_TAGS(NT), .MAX_RD_BYTES(MB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always @(posedge clk) begin
    if (!rst && bus.alloc_valid) begin
      assert (bus.alloc_bytes != '0) else $error("alloc_bytes is zero on alloc_valid");
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int m_lowest_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NT; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Monitor: pops the expectation due in this cycle and compares all visible outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("stale_expectation", cyc, e.cyc);
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("done_valid", int'(bus.done_valid), int'(e.done));
        if (e.done) chk("done_tag", int'(bus.done_tag), e.dtag);
        chk("err_valid", int'(bus.err_valid), int'(e.err));
        if (e.err) chk("err_tag", int'(bus.err_tag), e.etag);
        chk("outstanding", int'(bus.outstanding), e.outs);
        chk("alloc_ready", int'(bus.alloc_ready), int'(e.rdy));
        if (e.rdy) chk("alloc_tag", int'(bus.alloc_tag), e.atag);
      end else begin
        chk("idle_done_valid", int'(bus.done_valid), 0);
        chk("idle_err_valid", int'(bus.err_valid), 0);
      end
    end
  end

  // Drives one cycle of stimulus and pushes the model's expected post-edge outputs.
  task automatic step(input bit av, input int ab, input bit cv, input int ct, input int cb);
    exp_t e;
    int   ft;
    int   n;
    bus.alloc_valid = av;
    bus.alloc_bytes = BW'(ab);
    bus.cpl_valid   = cv;
    bus.cpl_tag     = TW'(ct);
    bus.cpl_bytes   = BW'(cb);
    ft     = m_lowest_free();
    e.done = 1'b0;
    e.dtag = 0;
    e.err  = 1'b0;
    e.etag = 0;
    if (cv) begin
      if (m_busy[ct]) begin
        if (cb < m_rem[ct]) begin
          m_rem[ct] -= cb;
        end else begin
          e.done = 1'b1;
          e.dtag = ct;
          if (cb > m_rem[ct] && ErrChk) begin
            e.err  = 1'b1;
            e.etag = ct;
          end
          m_busy[ct] = 1'b0;
          m_rem[ct]  = 0;
        end
      end else if (ErrChk) begin
        e.err  = 1'b1;
        e.etag = ct;
      end
    end
    if (av && ft >= 0) begin
      m_busy[ft] = 1'b1;
      m_rem[ft]  = ab;
    end
    e.outs = m_count();
    n      = m_lowest_free();
    e.rdy  = (n >= 0);
    e.atag = (n < 0) ? 0 : n;
    e.cyc  = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.alloc_bytes = '0;
    bus.cpl_valid   = 1'b0;
    bus.cpl_tag     = '0;
    bus.cpl_bytes   = '0;
    q.delete();
    for (int i = 0; i < NT; i++) begin
      m_busy[i] = 1'b0;
      m_rem[i]  = 0;
    end
    @(negedge clk);
    chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
    chk("rst_alloc_tag", int'(bus.alloc_tag), 0);
    chk("rst_done_valid", int'(bus.done_valid), 0);
    chk("rst_done_tag", int'(bus.done_tag), 0);
    chk("rst_err_valid", int'(bus.err_valid), 0);
    chk("rst_err_tag", int'(bus.err_tag), 0);
    chk("rst_outstanding", int'(bus.outstanding), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < NT; t++) begin
      if (m_busy[t]) step(1'b0, 0, 1'b1, t, m_rem[t]);
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit av, cv;
    int ab, ct, cb;
    int busyq[$];

    do_reset();

    // Fill the pool with alloc_valid held, then hold it one more cycle while full.
    for (int i = 0; i < NT; i++) step(1'b1, $urandom_range(1, MB), 1'b0, 0, 0);
    step(1'b1, 64, 1'b0, 0, 0);

    // Full pool: complete tag 5 while still requesting; tag 5 must be regranted.
    step(1'b1, 200, 1'b1, 5, m_rem[5]);
    step(1'b1, 200, 1'b0, 0, 0);
    drain();

    // 512 B on tag 0 returned as eight back-to-back 64 B completions.
    step(1'b1, 512, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 0, 64);
    idle();

    // Overrun: 100 B on tag 3 answered with 128 B.
    step(1'b1, 300, 1'b0, 0, 0);
    step(1'b1, 300, 1'b0, 0, 0);
    step(1'b1, 300, 1'b0, 0, 0);
    step(1'b1, 100, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 3, 128);
    drain();

    // Completion to free tag 9.
    step(1'b0, 0, 1'b1, 9, 40);
    idle();

    // Random mix of allocations and completions, including same-cycle pairs.
    for (int k = 0; k < 3000; k++) begin
      busyq.delete();
      for (int t = 0; t < NT; t++) if (m_busy[t]) busyq.push_back(t);
      av = ($urandom_range(0, 1) == 1);
      ab = $urandom_range(1, MB);
      cv = ($urandom_range(0, 2) != 0);
      if (busyq.size() == 0 || $urandom_range(0, 15) == 0) ct = $urandom_range(0, NT - 1);
      else ct = busyq[$urandom_range(0, busyq.size() - 1)];
      if (m_busy[ct] && $urandom_range(0, 9) != 0) cb = $urandom_range(1, m_rem[ct]);
      else cb = $urandom_range(1, MB);
      step(av, ab, cv, ct, cb);
    end
    drain();

    // Reset with ten partially completed tags; a late completion then hits a free tag.
    for (int i = 0; i < 10; i++) step(1'b1, 512, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, i, 64);
    do_reset();
    idle();
    step(1'b0, 0, 1'b1, 2, 64);
    idle();
    idle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
